part_init_bridge: RTL and testbench

PART_INIT_BRIDGE -- requirements
Module: part_init_bridge

---
 rtl/part_bridge_pkg.sv | 23 ++
 rtl/part_init_bridge_if.sv | 24 ++
 rtl/part_bridge_edge_cap.sv | 47 ++++
 rtl/part_init_bridge.sv | 147 ++++++++++++++
 tb/tb_part_init_bridge.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/part_bridge_pkg.sv
// rtl/part_bridge_pkg.sv - shared types and helpers for the partition init bridge
package part_bridge_pkg;

    localparam int PB_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_ERR
    } bridge_state_e;

    typedef struct packed {
        logic             wen;
        logic [PB_DW-1:0] data;
    } payload_t;

    // Channel index width; a single channel still needs one bit on the link.
    function automatic int chw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/part_init_bridge_if.sv
// rtl/part_init_bridge_if.sv - put/get link between the bridge and the target
interface part_init_bridge_if #(
    parameter int CHW = 2,
    parameter int DW  = 8
);
    logic           put_valid_o;
    logic           put_ready_i;
    logic [CHW-1:0] put_ch_o;
    logic [DW:0]    put_data_o;
    logic           get_valid_i;
    logic           get_ready_o;
    logic [CHW-1:0] get_ch_i;
    logic [DW:0]    get_data_i;

    modport master (
        output put_valid_o, put_ch_o, put_data_o, get_ready_o,
        input  put_ready_i, get_valid_i, get_ch_i, get_data_i
    );

    modport slave (
        input  put_valid_o, put_ch_o, put_data_o, get_ready_o,
        output put_ready_i, get_valid_i, get_ch_i, get_data_i
    );
endinterface

// File: rtl/part_bridge_edge_cap.sv
// rtl/part_bridge_edge_cap.sv - per-channel mission clock edge detector and payload snapshot
module part_bridge_edge_cap #(
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          mclk_i,
    input  logic          wen_i,
    input  logic [DW-1:0] data_i,
    input  logic          busy_i,
    input  logic          clr_i,
    output logic          pending_o,
    output logic [DW:0]   snap_o,
    output logic          ovr_o
);
    logic        sync_q;
    logic        dly_q;
    logic        pend_q;
    logic [DW:0] snap_q;
    logic        rise_w;

    assign rise_w = sync_q & ~dly_q;
    // A clear in the same cycle as an edge still sees pend_q set, so it is an overrun.
    assign ovr_o  = rise_w & (pend_q | busy_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
            pend_q <= 1'b0;
            snap_q <= '0;
        end else begin
            sync_q <= mclk_i;
            dly_q  <= sync_q;
            if (clr_i) begin
                pend_q <= 1'b0;
            end else if (rise_w && !busy_i && !pend_q) begin
                pend_q <= 1'b1;
                snap_q <= {wen_i, data_i};
            end
        end
    end

    assign pending_o = pend_q;
    assign snap_o    = snap_q;

endmodule

// File: rtl/part_init_bridge.sv
// rtl/part_init_bridge.sv - exports mission-clock channel writes over a put/get link and imports responses
module part_init_bridge
    import part_bridge_pkg::*;
#(
    parameter int N_CH   = 3,
    parameter int DW     = PB_DW,
    parameter int WD_MAX = 10000,
    parameter int OUT_CH = N_CH - 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_CH-1:0]     mclk_i,
    input  logic [N_CH-1:0]     wen_i,
    input  logic [N_CH*DW-1:0]  data_i,
    part_init_bridge_if.master  link,
    output logic [N_CH-1:0]     freeze_clk_o,
    output logic                valid_o,
    output logic [DW-1:0]       o_data_o,
    output logic                wd_err_o,
    output logic                ovr_err_o,
    output logic                mis_err_o
);
    localparam int             CHW     = chw(N_CH);
    localparam int             WDW     = $clog2(WD_MAX + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(WD_MAX - 1);

    bridge_state_e   state_q;
    logic [CHW-1:0]  cur_ch_q;
    logic [DW:0]     put_data_q;
    logic            put_valid_q;
    logic            get_ready_q;
    logic [WDW-1:0]  wd_cnt_q;
    logic            wd_err_q;
    logic            ovr_err_q;
    logic            mis_err_q;
    logic [DW:0]     rx_q [N_CH];
    logic [N_CH-1:0] freeze_q;

    logic [N_CH-1:0] pend_w;
    logic [N_CH-1:0] clr_w;
    logic [N_CH-1:0] busy_w;
    logic [N_CH-1:0] ovr_w;
    logic [DW:0]     snap_w [N_CH];
    logic            any_pend;
    logic [CHW-1:0]  sel_ch;

    for (genvar c = 0; c < N_CH; c++) begin : g_cap
        part_bridge_edge_cap #(.DW(DW)) u_cap (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .mclk_i    (mclk_i[c]),
            .wen_i     (wen_i[c]),
            .data_i    (data_i[c*DW +: DW]),
            .busy_i    (busy_w[c]),
            .clr_i     (clr_w[c]),
            .pending_o (pend_w[c]),
            .snap_o    (snap_w[c]),
            .ovr_o     (ovr_w[c])
        );
    end

    // Lowest-index pending channel wins; the downward scan leaves the smallest index last.
    always_comb begin
        any_pend = |pend_w;
        sel_ch   = '0;
        clr_w    = '0;
        busy_w   = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (pend_w[c]) sel_ch = CHW'(c);
        end
        if (state_q == ST_IDLE && any_pend) clr_w[sel_ch] = 1'b1;
        if (state_q == ST_SEND || state_q == ST_WAIT) busy_w[cur_ch_q] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cur_ch_q    <= '0;
            put_data_q  <= '0;
            put_valid_q <= 1'b0;
            get_ready_q <= 1'b0;
            wd_cnt_q    <= '0;
            wd_err_q    <= 1'b0;
            mis_err_q   <= 1'b0;
            for (int c = 0; c < N_CH; c++) rx_q[c] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_pend) begin
                        cur_ch_q    <= sel_ch;
                        put_data_q  <= snap_w[sel_ch];
                        put_valid_q <= 1'b1;
                        state_q     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (link.put_ready_i) begin
                        put_valid_q <= 1'b0;
                        get_ready_q <= 1'b1;
                        wd_cnt_q    <= '0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (link.get_valid_i && link.get_ch_i == cur_ch_q) begin
                        rx_q[cur_ch_q] <= link.get_data_i;
                        get_ready_q    <= 1'b0;
                        state_q        <= ST_IDLE;
                    end else begin
                        // Responses for other channels are consumed so the link never stalls.
                        if (link.get_valid_i) mis_err_q <= 1'b1;
                        if (wd_cnt_q == WD_LAST) begin
                            get_ready_q <= 1'b0;
                            wd_err_q    <= 1'b1;
                            state_q     <= ST_ERR;
                        end else begin
                            wd_cnt_q <= wd_cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            freeze_q  <= '0;
            ovr_err_q <= 1'b0;
        end else begin
            freeze_q  <= (state_q == ST_ERR) ? '1 : (pend_w | busy_w);
            ovr_err_q <= ovr_err_q | (|ovr_w);
        end
    end

    assign link.put_valid_o = put_valid_q;
    assign link.put_ch_o    = cur_ch_q;
    assign link.put_data_o  = put_data_q;
    assign link.get_ready_o = get_ready_q;
    assign freeze_clk_o     = freeze_q;
    assign valid_o          = rx_q[OUT_CH][DW];
    assign o_data_o         = rx_q[OUT_CH][DW-1:0];
    assign wd_err_o         = wd_err_q;
    assign ovr_err_o        = ovr_err_q;
    assign mis_err_o        = mis_err_q;

endmodule

// File: tb/tb_part_init_bridge.sv
// tb/tb_part_init_bridge.sv - self-checking bench for part_init_bridge
module tb_part_init_bridge;
    import part_bridge_pkg::*;

    localparam int N_CH = 3;
    localparam int DW   = 8;
    localparam int WD   = 16;
    localparam int OUTC = 2;
    localparam int CHW  = chw(N_CH);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N_CH-1:0]     mclk = '0;
    logic [N_CH-1:0]     wen = '0;
    logic [N_CH*DW-1:0]  data = '0;
    logic [N_CH-1:0]     freeze;
    logic                valid;
    logic [DW-1:0]       odata;
    logic                wd_err, ovr_err, mis_err;

    int n_checks = 0;
    int n_pass   = 0;

    bit             m_ovr, m_mis, m_valid;
    logic [DW-1:0]  m_odata;

    always #5 clk = ~clk;

    part_init_bridge_if #(.CHW(CHW), .DW(DW)) link ();

    part_init_bridge #(.N_CH(N_CH), .DW(DW), .WD_MAX(WD), .OUT_CH(OUTC)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .mclk_i       (mclk),
        .wen_i        (wen),
        .data_i       (data),
        .link         (link),
        .freeze_clk_o (freeze),
        .valid_o      (valid),
        .o_data_o     (odata),
        .wd_err_o     (wd_err),
        .ovr_err_o    (ovr_err),
        .mis_err_o    (mis_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [8:0] mk_pl(input logic w, input logic [7:0] d);
        payload_t p;
        p.wen  = w;
        p.data = d;
        return p;
    endfunction

    task automatic set_ch(input int c, input logic [8:0] pl);
        wen[c]          = pl[8];
        data[c*DW +: DW] = pl[7:0];
    endtask

    task automatic model_rsp(input int c, input logic [8:0] pl);
        if (c == OUTC) begin
            m_valid = pl[8];
            m_odata = pl[7:0];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mclk = '0;
        link.put_ready_i = 1'b0;
        link.get_valid_i = 1'b0;
        link.get_ch_i    = '0;
        link.get_data_i  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ovr = 0; m_mis = 0; m_valid = 0; m_odata = '0;
    endtask

    task automatic serve_put(input string tag, input int exp_ch, input logic [8:0] exp_pl, input int hold);
        int n = 0;
        int bad = 0;
        logic [8:0] pl0;
        while (!link.put_valid_o && n < 50) begin @(negedge clk); n++; end
        check_eq({tag, "_put_seen"}, 32'(link.put_valid_o), 1);
        check_eq({tag, "_put_ch"}, 32'(link.put_ch_o), exp_ch);
        check_eq({tag, "_put_data"}, 32'(link.put_data_o), 32'(exp_pl));
        pl0 = link.put_data_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!link.put_valid_o || link.put_data_o !== pl0) bad++;
        end
        check_eq({tag, "_put_hold"}, bad, 0);
        link.put_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        link.put_ready_i = 1'b0;
    endtask

    task automatic respond(input int c, input logic [8:0] pl);
        int n = 0;
        while (!link.get_ready_o && n < 50) begin @(negedge clk); n++; end
        check_eq("get_ready_seen", 32'(link.get_ready_o), 1);
        link.get_valid_i = 1'b1;
        link.get_ch_i    = CHW'(c);
        link.get_data_i  = pl;
        @(posedge clk);
        @(negedge clk);
        link.get_valid_i = 1'b0;
    endtask

    initial begin
        int lat;
        int cnt;
        link.put_ready_i = 1'b0;
        link.get_valid_i = 1'b0;
        link.get_ch_i    = '0;
        link.get_data_i  = '0;

        repeat (2) @(negedge clk);
        check_eq("reset_outputs", {link.put_valid_o, link.get_ready_o, freeze, valid, odata,
                                   wd_err, ovr_err, mis_err}, 0);
        do_reset();

        // Minimum round trip on OUT_CH with an always-ready target.
        link.put_ready_i = 1'b1;
        link.get_valid_i = 1'b1;
        link.get_ch_i    = CHW'(2);
        link.get_data_i  = 9'h1AB;
        set_ch(2, mk_pl(1'b1, 8'h33));
        mclk[2] = 1'b1;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (valid && lat == 99) lat = i;
        end
        @(negedge clk);
        link.put_ready_i = 1'b0;
        link.get_valid_i = 1'b0;
        mclk = '0;
        model_rsp(2, 9'h1AB);
        check_eq("min_latency", lat, 5);
        check_eq("out_valid", 32'(valid), 32'(m_valid));
        check_eq("out_data", 32'(odata), 32'(m_odata));

        // ch0 export, mismatched response, overrun, then matching response.
        set_ch(0, mk_pl(1'b1, 8'h5A));
        mclk[0] = 1'b1;
        repeat (2) @(negedge clk);
        mclk[0] = 1'b0;
        serve_put("ch0", 0, 9'h15A, 0);
        check_eq("ch0_freeze_wait", 32'(freeze[0]), 1);
        respond(1, 9'h055);
        m_mis = 1;
        check_eq("mis_err", 32'(mis_err), 32'(m_mis));
        check_eq("mis_still_wait", 32'(link.get_ready_o), 1);
        set_ch(0, mk_pl(1'b0, 8'hFF));
        mclk[0] = 1'b1;
        @(negedge clk);
        mclk[0] = 1'b0;
        repeat (3) @(negedge clk);
        m_ovr = 1;
        check_eq("ovr_err", 32'(ovr_err), 32'(m_ovr));
        respond(0, 9'h1C3);
        repeat (2) @(negedge clk);
        check_eq("ch0_freeze_fall", 32'(freeze[0]), 0);
        check_eq("out_hold_valid", 32'(valid), 32'(m_valid));
        check_eq("out_hold_data", 32'(odata), 32'(m_odata));
        cnt = 0;
        repeat (6) begin @(negedge clk); if (link.put_valid_o) cnt++; end
        check_eq("ovr_no_rearm", cnt, 0);

        // Simultaneous ch0 and ch2 edges.
        set_ch(0, mk_pl(1'b0, 8'h11));
        set_ch(2, mk_pl(1'b1, 8'h22));
        mclk = 3'b101;
        repeat (2) @(negedge clk);
        mclk = '0;
        serve_put("sim0", 0, mk_pl(1'b0, 8'h11), 0);
        check_eq("sim_freeze2_a", 32'(freeze[2]), 1);
        respond(0, 9'h0EE);
        serve_put("sim2", 2, mk_pl(1'b1, 8'h22), 0);
        check_eq("sim_freeze2_b", 32'(freeze[2]), 1);
        respond(2, 9'h0C4);
        model_rsp(2, 9'h0C4);
        repeat (2) @(negedge clk);
        check_eq("sim_freeze2_c", 32'(freeze[2]), 0);
        check_eq("sim_out_valid", 32'(valid), 32'(m_valid));
        check_eq("sim_out_data", 32'(odata), 32'(m_odata));

        // Held-off put, then asynchronous reset in WAIT.
        set_ch(1, mk_pl(1'b0, 8'hA7));
        mclk[1] = 1'b1;
        repeat (2) @(negedge clk);
        mclk = '0;
        serve_put("hold", 1, 9'h0A7, 7);
        check_eq("hold_in_wait", 32'(link.get_ready_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_outputs", {link.put_valid_o, link.get_ready_o, freeze, valid, odata,
                                       wd_err, ovr_err, mis_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ovr = 0; m_mis = 0; m_valid = 0; m_odata = '0;
        cnt = 0;
        repeat (10) begin @(negedge clk); if (link.put_valid_o || link.get_ready_o) cnt++; end
        check_eq("rst_no_replay", cnt, 0);

        // Watchdog expiry.
        set_ch(1, mk_pl(1'b1, 8'h3C));
        mclk[1] = 1'b1;
        repeat (2) @(negedge clk);
        mclk = '0;
        serve_put("wd", 1, 9'h13C, 0);
        lat = 99;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (wd_err && lat == 99) lat = i;
        end
        check_eq("wd_cycles", lat, WD);
        check_eq("err_handshake", {link.put_valid_o, link.get_ready_o}, 0);
        check_eq("err_freeze", 32'(freeze), 32'h7);
        mclk[0] = 1'b1;
        cnt = 0;
        repeat (8) begin @(negedge clk); mclk = '0; if (link.put_valid_o) cnt++; end
        check_eq("err_absorbing", cnt, 0);
        check_eq("err_freeze_hold", 32'(freeze), 32'h7);
        do_reset();

        // Randomized bursts against the transaction-level model.
        for (int b = 0; b < 25; b++) begin
            logic [2:0] mask;
            logic [8:0] pl [3];
            logic [8:0] rsp;
            int re;
            mask = 3'($urandom_range(1, 7));
            for (int c = 0; c < 3; c++) begin
                pl[c] = 9'($urandom);
                set_ch(c, pl[c]);
            end
            mclk = mask;
            re = -1;
            if ($urandom_range(0, 2) == 0) begin
                re = $urandom_range(0, 2);
                while (!mask[re]) re = (re + 1) % 3;
            end
            repeat (2) @(negedge clk);
            mclk = '0;
            if (re >= 0) begin
                @(negedge clk);
                set_ch(re, ~pl[re]);
                mclk[re] = 1'b1;
                m_ovr = 1;
                @(negedge clk);
                mclk = '0;
            end
            for (int c = 0; c < 3; c++) begin
                if (mask[c]) begin
                    serve_put("rnd", c, pl[c], $urandom_range(0, 5));
                    if ($urandom_range(0, 2) == 0) begin
                        respond((c + 1) % 3, 9'($urandom));
                        m_mis = 1;
                    end
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    rsp = 9'($urandom);
                    respond(c, rsp);
                    model_rsp(c, rsp);
                end
            end
            repeat (2) @(negedge clk);
            check_eq("rnd_ovr", 32'(ovr_err), 32'(m_ovr));
            check_eq("rnd_mis", 32'(mis_err), 32'(m_mis));
            check_eq("rnd_valid", 32'(valid), 32'(m_valid));
            check_eq("rnd_data", 32'(odata), 32'(m_odata));
            check_eq("rnd_freeze", 32'(freeze), 0);
            check_eq("rnd_wd", 32'(wd_err), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
